// File: rtl/sized_data_ram_pkg.sv
// Shared definitions for the sized data RAM: access sizes, FSM states and
// the fault / load-extension helpers used by the top level.
package sized_data_ram_pkg;

  localparam int WORDSIZE = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // A request faults on the illegal size code or on a natural-alignment miss.
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      SIZE_B:  f = 1'b0;
      SIZE_H:  f = off[0];
      SIZE_W:  f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Pick the addressed byte/half out of a big-endian word, right-justify it
  // and sign- or zero-extend it.
  function automatic logic [WORDSIZE-1:0] extend_load(
    input logic [WORDSIZE-1:0] word,
    input logic [1:0]          size,
    input logic [1:0]          off,
    input logic                uns
  );
    logic [7:0]          b;
    logic [15:0]         h;
    logic [WORDSIZE-1:0] res;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SIZE_B:  res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_H:  res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SIZE_W:  res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sized_data_ram_if.sv
// Request/response bundle between the MEM stage and the sized data RAM.
interface sized_data_ram_if #(
  parameter int AW = 32
);
  logic [AW-1:0] addr;
  logic [31:0]   write_data;
  logic          memread;
  logic          memwrite;
  logic [1:0]    size;
  logic          unsigned_ld;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          misaligned;
  logic          busy;

  modport master (
    output addr, write_data, memread, memwrite, size, unsigned_ld,
    input  read_data, read_valid, misaligned, busy
  );

  modport slave (
    input  addr, write_data, memread, memwrite, size, unsigned_ld,
    output read_data, read_valid, misaligned, busy
  );
endinterface

// File: rtl/sized_data_ram_byte_lane_bank.sv
// One byte lane of the data RAM: a WORDS x 8 array with one write port and a
// registered, enable-held read port. A read and write to the same index in one
// cycle returns the old contents.
module sized_data_ram_byte_lane_bank #(
  parameter int WORDS  = 256,
  parameter int WIDX_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [WIDX_W-1:0] widx,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [WIDX_W-1:0] ridx,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [WORDS];

  // Write port: stores and the clear sequence land here.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  // Read port: captures only on an accepted load so the result stays put.
  always_ff @(posedge CLK) begin
    if (re) begin
      rdata <= mem_r[ridx];
    end
  end

endmodule

// File: rtl/sized_data_ram.sv
// Byte-addressed big-endian data RAM with byte/half/word access, registered
// sign/zero-extended loads, alignment fault detection and a post-reset clear.
module sized_data_ram
  import sized_data_ram_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = 32,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input logic           CLK,
  input logic           reset,
  sized_data_ram_if.slave bus
);

  localparam int WORDS  = DEPTH_BYTES / 4;
  localparam int WIDX_W = IDX_W - 2;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

  state_t              state_r;
  logic [WIDX_W-1:0]   cnt_r;
  logic                busy_r;
  logic                read_valid_r;
  logic                misaligned_r;
  logic                ld_zero_r;
  logic [1:0]          ld_size_r;
  logic [1:0]          ld_off_r;
  logic                ld_uns_r;

  logic [1:0]          off_s;
  logic [WIDX_W-1:0]   req_idx_s;
  logic                fault_s;
  logic                idle_s;
  logic                do_store_s;
  logic                do_load_s;
  logic [3:0]          lane_we_s;
  logic [3:0][7:0]     lane_wdata_s;
  logic [WIDX_W-1:0]   widx_s;
  logic [3:0][7:0]     lane_rdata_s;
  logic [WORDSIZE-1:0] rd_word_s;
  logic                unused_addr_s;

  // Address bits above the array size only alias, so they are dropped.
  assign unused_addr_s = ^bus.addr[AW-1:IDX_W];

  assign off_s      = bus.addr[1:0];
  assign req_idx_s  = bus.addr[IDX_W-1:2];
  assign fault_s    = is_fault(bus.size, off_s);
  assign idle_s     = (state_r == ST_IDLE) && !reset;
  assign do_store_s = idle_s && bus.memwrite && !fault_s;
  assign do_load_s  = idle_s && bus.memread && !fault_s;

  // Lane steering: clear writes zero to every lane, stores hit only the
  // addressed lanes with big-endian byte order (lane 0 = lowest address).
  always_comb begin
    lane_we_s    = 4'b0000;
    lane_wdata_s = {4{8'h00}};
    widx_s       = req_idx_s;
    if (state_r == ST_CLEAR) begin
      lane_we_s = 4'b1111;
      widx_s    = cnt_r;
    end else if (do_store_s) begin
      case (bus.size)
        SIZE_W: begin
          lane_we_s       = 4'b1111;
          lane_wdata_s[0] = bus.write_data[31:24];
          lane_wdata_s[1] = bus.write_data[23:16];
          lane_wdata_s[2] = bus.write_data[15:8];
          lane_wdata_s[3] = bus.write_data[7:0];
        end
        SIZE_H: begin
          if (off_s[1]) begin
            lane_we_s       = 4'b1100;
            lane_wdata_s[2] = bus.write_data[15:8];
            lane_wdata_s[3] = bus.write_data[7:0];
          end else begin
            lane_we_s       = 4'b0011;
            lane_wdata_s[0] = bus.write_data[15:8];
            lane_wdata_s[1] = bus.write_data[7:0];
          end
        end
        SIZE_B: begin
          lane_we_s    = 4'b0001 << off_s;
          lane_wdata_s = {4{bus.write_data[7:0]}};
        end
        default: begin
          lane_we_s = 4'b0000;
        end
      endcase
    end else begin
      lane_we_s = 4'b0000;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    sized_data_ram_byte_lane_bank #(
      .WORDS  (WORDS),
      .WIDX_W (WIDX_W)
    ) u_bank (
      .CLK   (CLK),
      .we    (lane_we_s[k]),
      .widx  (widx_s),
      .wdata (lane_wdata_s[k]),
      .re    (do_load_s),
      .ridx  (req_idx_s),
      .rdata (lane_rdata_s[k])
    );
  end

  assign rd_word_s = {lane_rdata_s[0], lane_rdata_s[1], lane_rdata_s[2], lane_rdata_s[3]};

  // Control FSM: clear sequence after reset, then request handling with
  // single-cycle response pulses and captured load-formatting controls.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r      <= ST_CLEAR;
      cnt_r        <= {WIDX_W{1'b0}};
      busy_r       <= 1'b1;
      read_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
      ld_zero_r    <= 1'b1;
      ld_size_r    <= SIZE_W;
      ld_off_r     <= 2'b00;
      ld_uns_r     <= 1'b0;
    end else begin
      read_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + WIDX_W'(1);
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        ST_IDLE: begin
          busy_r       <= 1'b0;
          misaligned_r <= fault_s && (bus.memread || bus.memwrite);
          if (bus.memread) begin
            read_valid_r <= 1'b1;
            ld_zero_r    <= fault_s;
            ld_size_r    <= bus.size;
            ld_off_r     <= off_s;
            ld_uns_r     <= bus.unsigned_ld;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {WIDX_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Faulting loads and reset force zero; otherwise format the captured word.
  assign bus.read_data  = ld_zero_r ? {WORDSIZE{1'b0}}
                                    : extend_load(rd_word_s, ld_size_r, ld_off_r, ld_uns_r);
  assign bus.read_valid = read_valid_r;
  assign bus.misaligned = misaligned_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_sized_data_ram.sv
// Directed bench for sized_data_ram: clear timing, big-endian stores/loads,
// extension, faults, read-before-write, aliasing and reset during clear.
module tb_sized_data_ram;

  logic CLK;
  logic reset;
  int   checks;
  int   failures;
  int   nbusy;
  bit   seen;

  sized_data_ram_if #(.AW(32)) bus ();

  sized_data_ram #(.DEPTH_BYTES(1024), .AW(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic uns);
    bus.memread     = rd;
    bus.memwrite    = wr;
    bus.size        = sz;
    bus.addr        = a;
    bus.write_data  = wd;
    bus.unsigned_ld = uns;
    step();
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic uns, input logic [31:0] exp);
    do_op(1'b1, 1'b0, sz, a, 32'h0000_0000, uns);
    chk({tag, "_rv"}, {31'd0, bus.read_valid}, 32'd1);
    chk({tag, "_mis"}, {31'd0, bus.misaligned}, 32'd0);
    chk({tag, "_data"}, bus.read_data, exp);
  endtask

  // Counts cycles with busy high; pokes a load and a store mid-clear that
  // must be ignored. Bounded so a stuck busy still reaches the summary.
  task automatic count_busy(output int n, output bit pulse_seen);
    n = 0;
    pulse_seen = 1'b0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      bus.memread    = (n == 5);
      bus.memwrite   = (n == 6);
      bus.size       = 2'b10;
      bus.addr       = 32'h0000_0010;
      bus.write_data = 32'hFFFF_FFFF;
      step();
      pulse_seen = pulse_seen | bus.read_valid | bus.misaligned;
    end
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.size = 2'b00;
    bus.addr = 32'h0;
    bus.write_data = 32'h0;
    bus.unsigned_ld = 1'b0;

    // 1: reset state and clear length
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_rv", {31'd0, bus.read_valid}, 32'd0);
    chk("rst_mis", {31'd0, bus.misaligned}, 32'd0);
    chk("rst_data", bus.read_data, 32'h0);
    count_busy(nbusy, seen);
    chk("clear_cycles", nbusy, 32'd256);
    chk("clear_no_pulse", {31'd0, seen}, 32'd0);
    ld("clr_w10", 2'b10, 32'h10, 1'b0, 32'h0000_0000);
    step();
    chk("idle_rv_low", {31'd0, bus.read_valid}, 32'd0);

    // 2: word store, byte loads in big-endian order
    do_op(1'b0, 1'b1, 2'b10, 32'h20, 32'h1122_3344, 1'b0);
    chk("st20_rv", {31'd0, bus.read_valid}, 32'd0);
    chk("st20_mis", {31'd0, bus.misaligned}, 32'd0);
    ld("b20", 2'b00, 32'h20, 1'b1, 32'h0000_0011);
    ld("b21", 2'b00, 32'h21, 1'b1, 32'h0000_0022);
    ld("b22", 2'b00, 32'h22, 1'b1, 32'h0000_0033);
    ld("b23", 2'b00, 32'h23, 1'b1, 32'h0000_0044);
    ld("w20", 2'b10, 32'h20, 1'b0, 32'h1122_3344);
    ld("h22u", 2'b01, 32'h22, 1'b1, 32'h0000_3344);

    // 3: sign/zero extension, partial-lane stores
    do_op(1'b0, 1'b1, 2'b00, 32'h41, 32'hAAAA_AA85, 1'b0);
    ld("b41s", 2'b00, 32'h41, 1'b0, 32'hFFFF_FF85);
    ld("b41u", 2'b00, 32'h41, 1'b1, 32'h0000_0085);
    do_op(1'b0, 1'b1, 2'b01, 32'h42, 32'h5555_8001, 1'b0);
    ld("h42s", 2'b01, 32'h42, 1'b0, 32'hFFFF_8001);
    ld("h42u", 2'b01, 32'h42, 1'b1, 32'h0000_8001);
    ld("w40", 2'b10, 32'h40, 1'b0, 32'h0085_8001);
    step();
    chk("hold_rv", {31'd0, bus.read_valid}, 32'd0);
    chk("hold_data", bus.read_data, 32'h0085_8001);

    // 4: faults, back to back
    do_op(1'b0, 1'b1, 2'b10, 32'h22, 32'hCAFE_BABE, 1'b0);
    chk("fw22_mis", {31'd0, bus.misaligned}, 32'd1);
    chk("fw22_rv", {31'd0, bus.read_valid}, 32'd0);
    do_op(1'b1, 1'b0, 2'b01, 32'h13, 32'h0, 1'b0);
    chk("fh13_mis", {31'd0, bus.misaligned}, 32'd1);
    chk("fh13_rv", {31'd0, bus.read_valid}, 32'd1);
    chk("fh13_data", bus.read_data, 32'h0);
    do_op(1'b1, 1'b0, 2'b11, 32'h00, 32'h0, 1'b0);
    chk("fs11_mis", {31'd0, bus.misaligned}, 32'd1);
    chk("fs11_rv", {31'd0, bus.read_valid}, 32'd1);
    chk("fs11_data", bus.read_data, 32'h0);
    do_op(1'b0, 1'b1, 2'b11, 32'h20, 32'hFFFF_FFFF, 1'b0);
    chk("fst11_mis", {31'd0, bus.misaligned}, 32'd1);
    do_op(1'b0, 1'b1, 2'b01, 32'h21, 32'hFFFF_FFFF, 1'b0);
    chk("fh21_mis", {31'd0, bus.misaligned}, 32'd1);
    ld("w20_after", 2'b10, 32'h20, 1'b0, 32'h1122_3344);

    // 5: read-before-write, aliasing, last slot
    do_op(1'b0, 1'b1, 2'b10, 32'h30, 32'h0102_0304, 1'b0);
    do_op(1'b1, 1'b1, 2'b10, 32'h30, 32'hDEAD_BEEF, 1'b0);
    chk("rbw_rv", {31'd0, bus.read_valid}, 32'd1);
    chk("rbw_data", bus.read_data, 32'h0102_0304);
    ld("w30_new", 2'b10, 32'h30, 1'b0, 32'hDEAD_BEEF);
    ld("w430", 2'b10, 32'h430, 1'b0, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 2'b00, 32'h434, 32'h0000_0077, 1'b0);
    ld("b34", 2'b00, 32'h34, 1'b1, 32'h0000_0077);
    do_op(1'b0, 1'b1, 2'b10, 32'h3FC, 32'hA5A5_F00F, 1'b0);
    chk("w3fc_mis", {31'd0, bus.misaligned}, 32'd0);
    ld("wlast_alias", 2'b10, 32'hFFFF_FFFC, 1'b0, 32'hA5A5_F00F);

    // 6: reset after a store and again mid-clear
    do_op(1'b0, 1'b1, 2'b10, 32'h50, 32'h1234_5678, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst2_data", bus.read_data, 32'h0);
    repeat (10) step();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(nbusy, seen);
    chk("reclear_cycles", nbusy, 32'd256);
    chk("reclear_no_pulse", {31'd0, seen}, 32'd0);
    ld("w50_clr", 2'b10, 32'h50, 1'b0, 32'h0000_0000);
    ld("w30_clr", 2'b10, 32'h30, 1'b0, 32'h0000_0000);
    ld("w10_clr", 2'b10, 32'h10, 1'b0, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sized_data_ram.md
Name: sized_data_ram

Overview:
- Byte-addressed, big-endian data memory for the core's MEM stage.
- Supports byte, halfword and word accesses.
- Loads are registered with sign or zero extension.
- Misaligned and illegal sizes are detected.
- After reset, a hardware clear sequence zeroes the array, with a busy indication while it runs.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; power of two, multiple of 4.
- AW, 32: address port width.
- IDX_W, $clog2(DEPTH_BYTES): internal byte-index width (derived).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge CLK.
- addr  in  AW  byte address; bits above IDX_W ignored (wrap-around).
- write_data  in  32  store data; LSBs used for byte/half.
- memread  in  1  load request.
- memwrite  in  1  store request.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  in  1  1 = zero-extend, 0 = sign-extend (byte/half loads).
- read_data  out  32  registered load result.
- read_valid  out  1  one-cycle pulse, 1 cycle after an accepted load.
- misaligned  out  1  one-cycle pulse, 1 cycle after a faulting request.
- busy  out  1  high during the clear sequence; requests are ignored.

Behaviour:
- Reset, sampled high on posedge:
  - read_data=0, read_valid=0, misaligned=0, busy=1, clear counter=0, FSM->CLEAR.
  - Reset asserted mid-clear or mid-access restarts the clear from 0.
  - Any pending access is discarded.
- FSM CLEAR:
  - Each cycle writes zero to word index cnt in all 4 lanes, then cnt++.
  - At cnt = DEPTH_BYTES/4-1 the FSM goes to IDLE; busy deasserts on the following cycle.
  - Total is DEPTH_BYTES/4 cycles with busy=1.
  - memread/memwrite are ignored (no write, no read_valid, no misaligned).
- FSM IDLE, fault check:
  - Fault if size=11, or half with addr[0]=1, or word with addr[1:0]!=00.
  - Faulting store: no array change; misaligned=1 next cycle.
  - Faulting load: read_valid=1, read_data=0, misaligned=1 next cycle.
- FSM IDLE, store (memwrite, no fault), big-endian:
  - Word: mem[a]=wd[31:24], a+1=[23:16], a+2=[15:8], a+3=[7:0].
  - Half: mem[a]=wd[15:8], a+1=wd[7:0].
  - Byte: mem[a]=wd[7:0].
  - Only the addressed lanes are written.
- FSM IDLE, load (memread, no fault):
  - 1-cycle latency: read_data and read_valid update on the next posedge.
  - Byte/half results are right-justified, then sign- or zero-extended per unsigned_ld.
  - read_data holds its value until the next accepted load or reset; read_valid is 0 otherwise.
- Simultaneous memread and memwrite:
  - Both execute.
  - Load returns pre-write (old) data for overlapping bytes (read-before-write).
- misaligned and read_valid are single-cycle pulses; back-to-back requests each produce their own pulse.
- Wrap-around: addr is taken modulo DEPTH_BYTES. A word at the last aligned slot is legal; alignment guarantees no access crosses the end.

Decomposition:
- Shared package/defs:
  - WORDSIZE=32.
  - SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
  - FSM state encodings CLEAR/IDLE.
- Sub-module byte_lane_bank:
  - One DEPTH_BYTES/4 x 8 array per lane, instantiated ×4; lane 0 holds addr[1:0]=00 (MSB byte).
  - Ports: CLK, we, widx, wdata, ridx, rdata.
  - Registered read with read-before-write.
  - Enables a one-word-per-cycle clear.
- Top level holds:
  - FSM and clear counter.
  - Fault check.
  - Lane steering/enables.
  - Load extension.

Test Plan:
1. Reset 1 cycle, then hold idle: busy=1 for exactly DEPTH_BYTES/4 cycles (256 at default); a load of addr 0x10 issued during busy gives no read_valid; after busy falls, word load 0x10 -> 0x00000000.
2. Word store 0x11223344 @0x20; byte loads @0x20..0x23 unsigned -> 0x11,0x22,0x33,0x44; word load -> 0x11223344, read_valid 1 cycle later.
3. Byte store 0x85 @0x41: signed byte load -> 0xFFFFFF85, unsigned -> 0x00000085. Half store 0x8001 @0x42: signed half load -> 0xFFFF8001; word load @0x40 -> 0x00858001.
4. Word store @0x22, half load @0x13, size=11 @0x00: each gives misaligned pulse; no array change (word @0x20 unchanged); the faulting loads give read_data=0, read_valid=1.
5. Same cycle: memwrite word 0xDEADBEEF @0x30 (prior 0x01020304) and memread @0x30 -> read_data=0x01020304; next load -> 0xDEADBEEF. Address 0x400+0x30 aliases to 0x30.
6. Reset asserted 10 cycles into the clear, or 1 cycle after a store: clear restarts (busy for the full DEPTH_BYTES/4 cycles again); the stored word reads 0.
